// File: rtl/rcv_frame_queue.sv
// Receive frame queue: address filter, inline CRC-8 check, NUM_SLOTS-deep frame store, byte-stream delivery.
// Optional build macro RCV_DROP_BAD_EN: discard bad-CRC frames instead of delivering them with '!' status.
//
// Write FSM
//   state   | meaning
//   W_IDLE  | waiting for carrier rise
//   W_DEST  | carrier up, waiting for destination byte
//   W_RECV  | storing bytes of an accepted frame
//   W_SKIP  | frame not for us (or queue full); wait for carrier fall
//   W_DROP  | frame aborted on error/overlength; wait for carrier fall
//   W_CHECK | one cycle: length/CRC/type verdict, commit or discard
// Read FSM
//   state   | meaning
//   R_IDLE  | no frame at head (or between frames)
//   R_DATA  | presenting src/payload bytes from slot memory
//   R_STAT  | presenting status byte with rlast
module rcv_frame_queue #(
  parameter int          NUM_SLOTS = 4,
  parameter int          MAX_FRAME = 256,
  parameter int          ERRCNT_W  = 8,
  parameter logic [7:0]  BCAST     = 8'h2A
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  input  logic                cardet,
  input  logic                rx_error,
  input  logic [7:0]          MAC,
  input  logic                rrdy,
  output logic                rvalid,
  output logic [7:0]          rcvr_data,
  output logic                rlast,
  output logic                ACK_needed,
  output logic [7:0]          ack_dest,
  output logic                ACK_received,
  output logic [ERRCNT_W-1:0] rerrcnt,
  output logic [ERRCNT_W-1:0] ovfcnt
);

  localparam int PW = $clog2(NUM_SLOTS);
  localparam int AW = $clog2(MAX_FRAME);
  localparam int LW = AW + 1;
  localparam int CW = PW + 1;

  localparam logic [7:0] ST_GOOD = 8'h2B;
  localparam logic [7:0] ST_BAD  = 8'h21;

  typedef enum logic [2:0] {W_IDLE, W_DEST, W_RECV, W_SKIP, W_DROP, W_CHECK} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_STAT} rstate_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  wstate_t         wstate, wnext;
  rstate_t         rstate, rnext;

  logic            cardet_q;
  logic            cardet_rise;
  logic [LW-1:0]   wlen;
  logic [7:0]      crc;
  logic [7:0]      src_b;
  logic [7:0]      type_b;

  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            slot_free;

  logic [7:0]      mem      [NUM_SLOTS*MAX_FRAME];
  logic [LW-1:0]   len_mem  [NUM_SLOTS];
  logic [7:0]      stat_mem [NUM_SLOTS];
  logic [7:0]      rd_q;

  logic            mem_we, len_clr, err_inc, ovf_inc, commit;
  logic            ack_need_set, ack_rcv_set;
  logic [7:0]      commit_stat;

  logic [LW-1:0]   ridx, idx_nxt, head_len;
  logic [AW-1:0]   raddr_idx;
  logic            xfer, pop, idx_load, idx_adv;

  assign cardet_rise = cardet & ~cardet_q;
  assign slot_free   = (count != CW'(NUM_SLOTS));

  // ---------------- write side ----------------
  always_ff @(posedge clk) begin
    if (rst) wstate <= W_IDLE;
    else     wstate <= wnext;
  end

  always_comb begin
    wnext        = wstate;
    mem_we       = 1'b0;
    len_clr      = 1'b0;
    err_inc      = 1'b0;
    ovf_inc      = 1'b0;
    commit       = 1'b0;
    commit_stat  = ST_GOOD;
    ack_need_set = 1'b0;
    ack_rcv_set  = 1'b0;
    case (wstate)
      W_IDLE: begin
        len_clr = 1'b1;
        if (cardet_rise) wnext = W_DEST;
      end
      W_DEST: begin
        if (!cardet) wnext = W_IDLE;
        else if (rx_valid) begin
          if (rx_data == MAC || rx_data == BCAST) begin
            if (slot_free) begin
              wnext  = W_RECV;
              mem_we = 1'b1;
            end else begin
              wnext   = W_SKIP;
              ovf_inc = 1'b1;
            end
          end else begin
            wnext = W_SKIP;
          end
        end
      end
      W_RECV: begin
        if (rx_error) begin
          wnext   = W_DROP;
          err_inc = 1'b1;
        end else if (rx_valid && wlen == LW'(MAX_FRAME)) begin
          wnext   = W_DROP;
          err_inc = 1'b1;
        end else begin
          mem_we = rx_valid;
          if (!cardet) wnext = W_CHECK;
        end
      end
      W_SKIP, W_DROP: begin
        if (!cardet) wnext = W_IDLE;
      end
      W_CHECK: begin
        wnext = W_IDLE;
        if (wlen < LW'(4)) begin
          err_inc = 1'b1;
        end else if (crc != 8'h00) begin
          err_inc = 1'b1;
`ifdef RCV_DROP_BAD_EN
          commit = 1'b0;
`else
          commit      = 1'b1;
          commit_stat = ST_BAD;
`endif
        end else if (type_b == 8'h32) begin
          ack_rcv_set = 1'b1;
        end else if (type_b == 8'h31) begin
          ack_need_set = 1'b1;
          commit       = 1'b1;
        end else if (type_b == 8'h30) begin
          commit = 1'b1;
        end else begin
          err_inc = 1'b1;
        end
      end
      default: wnext = W_IDLE;
    endcase
  end

  // cardet_q tracks the line even in reset so a reset mid-carrier does not look like a new rise
  always_ff @(posedge clk) begin
    cardet_q <= cardet;
    if (rst) begin
      wlen         <= '0;
      crc          <= '0;
      src_b        <= '0;
      type_b       <= '0;
      rerrcnt      <= '0;
      ovfcnt       <= '0;
      ACK_needed   <= 1'b0;
      ACK_received <= 1'b0;
      ack_dest     <= '0;
    end else begin
      if (len_clr) begin
        wlen <= '0;
        crc  <= '0;
      end else if (mem_we) begin
        wlen <= wlen + LW'(1);
        crc  <= crc8_byte(crc, rx_data);
        if (wlen == LW'(1)) src_b  <= rx_data;
        if (wlen == LW'(2)) type_b <= rx_data;
      end
      if (err_inc && rerrcnt != '1) rerrcnt <= rerrcnt + 1'b1;
      if (ovf_inc && ovfcnt != '1)  ovfcnt  <= ovfcnt + 1'b1;
      ACK_needed   <= ack_need_set;
      ACK_received <= ack_rcv_set;
      if (ack_need_set) ack_dest <= src_b;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[{wr_ptr, wlen[AW-1:0]}] <= rx_data;
    if (commit) begin
      len_mem[wr_ptr]  <= wlen;
      stat_mem[wr_ptr] <= commit_stat;
    end
    rd_q <= mem[{rd_ptr, raddr_idx}];
  end

  // ---------------- queue bookkeeping ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({commit, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- read side ----------------
  // The memory address looks one byte ahead on a transfer, so rd_q always holds the byte
  // being presented: stable under stall, no bubble while rrdy stays high.
  assign head_len  = len_mem[rd_ptr];
  assign idx_nxt   = (ridx == LW'(1)) ? LW'(3) : ridx + LW'(1);
  assign rvalid    = (rstate != R_IDLE);
  assign rlast     = (rstate == R_STAT);
  assign xfer      = rvalid && rrdy;
  assign rcvr_data = (rstate == R_STAT) ? stat_mem[rd_ptr] :
                     (rstate == R_DATA) ? rd_q : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate <= R_IDLE;
      ridx   <= '0;
    end else begin
      rstate <= rnext;
      if (idx_load)     ridx <= LW'(1);
      else if (idx_adv) ridx <= idx_nxt;
    end
  end

  always_comb begin
    rnext     = rstate;
    raddr_idx = ridx[AW-1:0];
    pop       = 1'b0;
    idx_load  = 1'b0;
    idx_adv   = 1'b0;
    case (rstate)
      R_IDLE: begin
        raddr_idx = AW'(1);
        if (count != '0) begin
          rnext    = R_DATA;
          idx_load = 1'b1;
        end
      end
      R_DATA: begin
        if (xfer) begin
          if (idx_nxt >= head_len - LW'(1)) begin
            rnext = R_STAT;
          end else begin
            idx_adv   = 1'b1;
            raddr_idx = idx_nxt[AW-1:0];
          end
        end
      end
      R_STAT: begin
        if (xfer) begin
          pop   = 1'b1;
          rnext = R_IDLE;
        end
      end
      default: rnext = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rcv_frame_queue.sv
// Directed bench for rcv_frame_queue: filtering, CRC, ACK events, overflow, drops and reset.
// Honours RCV_DROP_BAD_EN for the bad-CRC expectation.
module tb_rcv_frame_queue;

  localparam int MAX_FRAME = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cardet = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] MAC = 8'h41;
  logic       rrdy = 1'b1;
  logic       rvalid;
  logic [7:0] rcvr_data;
  logic       rlast;
  logic       ACK_needed;
  logic [7:0] ack_dest;
  logic       ACK_received;
  logic [7:0] rerrcnt;
  logic [7:0] ovfcnt;

  rcv_frame_queue #(.NUM_SLOTS(4), .MAX_FRAME(MAX_FRAME), .ERRCNT_W(8), .BCAST(8'h2A)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .cardet(cardet),
    .rx_error(rx_error), .MAC(MAC), .rrdy(rrdy), .rvalid(rvalid), .rcvr_data(rcvr_data),
    .rlast(rlast), .ACK_needed(ACK_needed), .ack_dest(ack_dest), .ACK_received(ACK_received),
    .rerrcnt(rerrcnt), .ovfcnt(ovfcnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] gotq[$];
  logic       lastq[$];
  logic [7:0] expq[$];
  logic [7:0] txq[$];
  int         n_ackn = 0;
  int         n_ackr = 0;
  logic [7:0] ackd = 8'h00;

  // transfers complete on the next rising edge; sample just after inputs settle
  always @(negedge clk) begin
    #1;
    if (rvalid && rrdy) begin
      gotq.push_back(rcvr_data);
      lastq.push_back(rlast);
    end
    if (ACK_needed) begin
      n_ackn++;
      ackd = ack_dest;
    end
    if (ACK_received) n_ackr++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  task automatic start_frame();
    cardet = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic put_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic end_frame();
    cardet = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [7:0] s, input logic [7:0] t,
                            input string pl, input bit flip);
    logic [7:0] fcs;
    txq.delete();
    txq.push_back(d);
    txq.push_back(s);
    txq.push_back(t);
    for (int i = 0; i < pl.len(); i++) txq.push_back(8'(pl[i]));
    fcs = 8'h00;
    foreach (txq[i]) fcs = crc8(fcs, txq[i]);
    if (flip) txq[3] = txq[3] ^ 8'h01;
    txq.push_back(fcs);
    start_frame();
    foreach (txq[i]) put_byte(txq[i]);
    end_frame();
  endtask

  task automatic check_stream(input string tag, input int mark);
    chk({tag, "_n"}, gotq.size() - mark, expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (mark + i < gotq.size()) begin
        chk({tag, "_d"}, int'(gotq[mark + i]), int'(expq[i]));
        chk({tag, "_l"}, int'(lastq[mark + i]), (i == expq.size() - 1) ? 1 : 0);
      end
    end
  endtask

  int mark;
  int ackn0, ackr0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_data", rcvr_data, 0);
    chk("rst_rerr", rerrcnt, 0);
    chk("rst_ovf", ovfcnt, 0);
    chk("rst_ackn", ACK_needed, 0);
    chk("rst_ackr", ACK_received, 0);

    mark = gotq.size();
    send_frame(8'h41, 8'h42, 8'h30, "HI", 1'b0);
    expq = '{8'h42, 8'h48, 8'h49, 8'h2B};
    check_stream("good", mark);
    chk("good_rerr", rerrcnt, 0);

    mark = gotq.size();
    send_frame(8'h43, 8'h42, 8'h30, "HI", 1'b0);
    expq.delete();
    check_stream("other", mark);
    chk("other_rerr", rerrcnt, 0);
    chk("other_ovf", ovfcnt, 0);

    mark = gotq.size();
    send_frame(8'h2A, 8'h42, 8'h30, "HI", 1'b0);
    expq = '{8'h42, 8'h48, 8'h49, 8'h2B};
    check_stream("bcast", mark);

    mark = gotq.size();
    send_frame(8'h41, 8'h42, 8'h30, "HI", 1'b1);
`ifdef RCV_DROP_BAD_EN
    expq.delete();
`else
    expq = '{8'h42, 8'h49, 8'h49, 8'h21};
`endif
    check_stream("badcrc", mark);
    chk("badcrc_rerr", rerrcnt, 1);

    mark = gotq.size();
    ackn0 = n_ackn;
    ackr0 = n_ackr;
    send_frame(8'h41, 8'h55, 8'h31, "A", 1'b0);
    expq = '{8'h55, 8'h41, 8'h2B};
    check_stream("ackreq", mark);
    chk("ackreq_pulses", n_ackn - ackn0, 1);
    chk("ackreq_dest", ackd, 8'h55);
    chk("ackreq_nor", n_ackr - ackr0, 0);

    mark = gotq.size();
    send_frame(8'h41, 8'h55, 8'h32, "", 1'b0);
    expq.delete();
    check_stream("ackrcv", mark);
    chk("ackrcv_pulses", n_ackr - ackr0, 1);
    chk("ackrcv_non", n_ackn - ackn0, 1);

    start_frame();
    put_byte(8'h41);
    put_byte(8'h42);
    put_byte(8'h30);
    end_frame();
    chk("short_rerr", rerrcnt, 2);

    rrdy = 1'b0;
    mark = gotq.size();
    for (int i = 0; i < 5; i++) send_frame(8'h41, 8'(8'h60 + i), 8'h30, "Z", 1'b0);
    chk("ovf_cnt", ovfcnt, 1);
    chk("ovf_rerr", rerrcnt, 2);
    chk("stall_valid", rvalid, 1);
    chk("stall_data0", rcvr_data, 8'h60);
    repeat (3) @(negedge clk);
    chk("stall_data1", rcvr_data, 8'h60);
    chk("stall_last", rlast, 0);
    rrdy = 1'b1;
    repeat (40) @(negedge clk);
    expq = '{8'h60, 8'h5A, 8'h2B, 8'h61, 8'h5A, 8'h2B, 8'h62, 8'h5A, 8'h2B, 8'h63, 8'h5A, 8'h2B};
    for (int i = 0; i < expq.size(); i++)
      if (mark + i < gotq.size()) chk("ovf_order", gotq[mark + i], expq[i]);
    chk("ovf_n", gotq.size() - mark, 12);

    mark = gotq.size();
    start_frame();
    for (int i = 0; i < MAX_FRAME + 1; i++) put_byte((i == 0) ? 8'h41 : 8'h30);
    end_frame();
    chk("long_rerr", rerrcnt, 3);
    chk("long_n", gotq.size() - mark, 0);

    mark = gotq.size();
    start_frame();
    put_byte(8'h41);
    put_byte(8'h42);
    put_byte(8'h30);
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
    put_byte(8'h48);
    put_byte(8'h00);
    end_frame();
    chk("rxerr_rerr", rerrcnt, 4);
    chk("rxerr_n", gotq.size() - mark, 0);

    mark = gotq.size();
    start_frame();
    put_byte(8'h41);
    put_byte(8'h42);
    put_byte(8'h30);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    put_byte(8'h59);
    put_byte(8'h00);
    end_frame();
    chk("rstmid_rerr", rerrcnt, 0);
    chk("rstmid_ovf", ovfcnt, 0);
    chk("rstmid_n", gotq.size() - mark, 0);

    mark = gotq.size();
    send_frame(8'h41, 8'h42, 8'h30, "HI", 1'b0);
    expq = '{8'h42, 8'h48, 8'h49, 8'h2B};
    check_stream("after", mark);
    chk("after_rerr", rerrcnt, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
